// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Grants up to NUM_CDB of NUM_REQ writeback requesters each cycle. The grant is
// combinational and doubles as the unit's advance signal. Granted packets are
// registered and broadcast on the CDB slots one cycle later.
// Optional feature macro: CDB_ARB_LDU_PRIO_EN gives the load unit (NUM_REQ-1)
// fixed top priority on slot 0, with round-robin over the remaining units.

package cdb_arbiter_pkg;

    typedef struct packed {
        logic        is_valid;
        logic [4:0]  rob_tag;
        logic [5:0]  dest_reg;
        logic [31:0] value;
    } writeback_packet_t;

    localparam int unsigned PKT_W = $bits(writeback_packet_t);

endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_CDB = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [PKT_W-1:0]     req_packet [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_gnt,
    output logic [PKT_W-1:0]     cdb_packet [NUM_CDB]
);

`ifdef CDB_ARB_LDU_PRIO_EN
    localparam bit LDU_PRIO = 1'b1;
`else
    localparam bit LDU_PRIO = 1'b0;
`endif

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LDU_IDX = NUM_REQ - 1;
    // Number of indices that take part in round-robin rotation.
    localparam int unsigned RR_N    = LDU_PRIO ? (NUM_REQ - 1) : NUM_REQ;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] gnt_raw;
    logic [NUM_CDB-1:0] slot_vld;
    logic [PTR_W-1:0]   slot_sel [NUM_CDB];
    logic               rr_any;
    logic [PTR_W-1:0]   rr_next;
    writeback_packet_t  nxt_pkt [NUM_CDB];

    // Extract the request bit of every unit result register.
    always_comb begin
        active = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            active[i] = req_packet[i][PKT_W-1];
        end
    end

    // Grant selection: optional load-unit slot, then circular scan from rr_ptr,
    // filling the lowest free slot with each granted index in scan order.
    always_comb begin
        logic [RR_N-1:0]   act_rr;
        logic [2*RR_N-1:0] rot;
        logic [PTR_W:0]    sum;
        logic [PTR_W:0]    nxt;
        logic [PTR_W-1:0]  idx;
        logic              placed;

        gnt_raw  = '0;
        slot_vld = '0;
        rr_any   = 1'b0;
        rr_next  = rr_ptr;
        sum      = '0;
        nxt      = '0;
        idx      = '0;
        placed   = 1'b0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            slot_sel[k] = '0;
        end

        if (LDU_PRIO && active[LDU_IDX]) begin
            gnt_raw[LDU_IDX] = 1'b1;
            slot_vld[0]      = 1'b1;
            slot_sel[0]      = PTR_W'(LDU_IDX);
        end

        // Rotating the request vector lets the scan use constant bit positions.
        act_rr = active[RR_N-1:0];
        rot    = {act_rr, act_rr} >> rr_ptr;

        for (int unsigned off = 0; off < RR_N; off++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(RR_N)) begin
                sum = sum - (PTR_W+1)'(RR_N);
            end
            idx = sum[PTR_W-1:0];
            if (rot[off] && !(&slot_vld)) begin
                gnt_raw[idx] = 1'b1;
                placed = 1'b0;
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (!placed && !slot_vld[k]) begin
                        slot_vld[k] = 1'b1;
                        slot_sel[k] = idx;
                        placed      = 1'b1;
                    end
                end
                rr_any = 1'b1;
                nxt    = sum + (PTR_W+1)'(1);
                if (nxt >= (PTR_W+1)'(RR_N)) begin
                    rr_next = '0;
                end else begin
                    rr_next = nxt[PTR_W-1:0];
                end
            end
        end
    end

    // Grants are suppressed during reset and flush so no unit drops a packet.
    always_comb begin
        req_gnt = '0;
        if (rst && !flush) begin
            req_gnt = gnt_raw;
        end
    end

    // Build the next broadcast contents; unfilled or flushed slots are all-zero.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            nxt_pkt[k] = '0;
            if (slot_vld[k] && !flush) begin
                nxt_pkt[k]          = writeback_packet_t'(req_packet[slot_sel[k]]);
                nxt_pkt[k].is_valid = 1'b1;
            end
        end
    end

    // Broadcast registers and round-robin pointer; pointer holds on flush or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb_packet[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb_packet[k] <= nxt_pkt[k];
            end
            if (!flush && rr_any) begin
                rr_ptr <= rr_next;
            end
        end
    end

    a_gnt_count: assert property (@(posedge clk) disable iff (!rst)
        $countones(req_gnt) <= NUM_CDB);

    a_gnt_only_active: assert property (@(posedge clk) disable iff (!rst)
        (req_gnt & ~active) == '0);

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) between the execution units' writeback result registers. Each cycle it grants up to `NUM_CDB` of the `NUM_REQ` requesting units using round-robin priority. Each unit's grant is also its ready/advance signal, the same contract the ALU uses for its `*_cdb_gnt` input. Granted packets are registered and broadcast on the CDB ports one cycle later, to the reservation stations, ROB and register-status logic.

## Interface
- `NUM_REQ`, 4: number of requesting units (≥2); index `NUM_REQ-1` is the load unit.
- `NUM_CDB`, 2: number of CDB broadcast ports (1 ≤ `NUM_CDB` ≤ `NUM_REQ`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  pipeline flush (mispredict/exception), synchronous.
- `req_packet[NUM_REQ]`  in  `writeback_packet_t` each  unit result registers; `.is_valid` is the request.
- `req_gnt[NUM_REQ]`  out  1 each  grant, combinational same cycle; unit consumes its packet on grant.
- `cdb_packet[NUM_CDB]`  out  `writeback_packet_t` each  registered broadcast; `.is_valid` marks a live slot.

## Operation
- Request i is active when `req_packet[i].is_valid`=1.
- State: `rr_ptr` (`$clog2(NUM_REQ)` bits), `cdb_packet` output registers. No other FSM.
- Arbitration (combinational): scan indices circularly starting at `rr_ptr`. The first `NUM_CDB` active requests are granted. The k-th granted index (k=0 first in scan order) maps to CDB slot k.
- No more than `NUM_CDB` grants per cycle. Each requester gets at most one grant per cycle.
- Pointer update: when at least one round-robin grant is issued, `rr_ptr` ← (last granted index + 1) mod `NUM_REQ`. With no grants it holds. Wrap from `NUM_REQ-1` to 0.
- Output register: slot k ← granted packet, `.is_valid`=1. Slots left unfilled ← all-zero (`.is_valid`=0). A packet is broadcast exactly once.
- Flush: while `flush`=1, all `req_gnt`=0 and all slots load all-zero next edge. `rr_ptr` holds. An unflushed packet in a unit register stays in the unit; the unit clears it itself.
- Reset (`rst`=0, any cycle including mid-broadcast): immediately `cdb_packet` all-zero, `rr_ptr`=0, and all `req_gnt`=0 (gated) while reset is asserted.
- Requests arriving in the same cycle as a grant release are treated like any other requests; there is no back-to-back penalty.

## Timing
- Grant latency: 0 cycles. `req_gnt[i]` is valid in the same cycle as the request.
- Broadcast latency: a packet granted in cycle N appears on `cdb_packet` in cycle N+1, for one cycle only.
- Throughput: `NUM_CDB` results per cycle sustained.
- Fairness: any continuously requesting unit is granted within ⌈`NUM_REQ`/`NUM_CDB`⌉ cycles. With load priority compiled in, this bound applies to the non-load units using ⌈(`NUM_REQ`-1)/(`NUM_CDB`-1)⌉, which requires `NUM_CDB` ≥ 2.
- Combinational path: `req_packet.is_valid` → `req_gnt` only. `cdb_packet` is purely registered.

## Configuration
- `CDB_ARB_LDU_PRIO_EN` defined: requester `NUM_REQ-1` (load unit) has fixed top priority.
  - When active, it always takes slot 0.
  - The remaining `NUM_CDB-1` slots are filled round-robin over indices 0..`NUM_REQ-2`.
  - `rr_ptr` ranges over 0..`NUM_REQ-2` and updates only from round-robin grants.
- Not defined: pure round-robin over all `NUM_REQ` indices, as described in Operation.

## Test plan
- Reset: drive all four requests valid, then pull `rst` low mid-cycle → `cdb_packet[*].is_valid`=0 and `req_gnt`=0 asynchronously. After release, the first grants are {0,1}.
- Saturation (`NUM_REQ`=4, `NUM_CDB`=2, no macro, all valid every cycle) → grants {0,1}, {2,3}, {0,1}. In cycle 1, slot0 carries req0's `dest_reg` and slot1 carries req1's.
- Sparse: only req2 valid for 3 cycles → `req_gnt[2]`=1 every cycle, always on slot 0, slot 1 invalid, `rr_ptr`=3. Then req3 and req0 become valid → grant order 3, 0.
- Flush: req0 and req1 valid with `flush`=1 → `req_gnt`=0000, next cycle both slots invalid, `rr_ptr` unchanged.
- Macro on, all four valid → slot0=req3 every cycle; slot1 cycles req0, req1, req2, req0.
- Wrap: `rr_ptr`=3, req3 and req0 valid → slot0=req3, slot1=req0, `rr_ptr` becomes 1.
